// File: rtl/watchdog_timer_unit.sv
// Cycle-counting watchdog with warning, sticky trip flag and one-shot pulse.
// Define WDT_WINDOW_EN to trip on heartbeats that arrive too early.
module watchdog_timer_unit #(
  parameter int unsigned COUNTER_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 20,
  parameter int unsigned WARNING_CYCLES    = 15,
  parameter int unsigned WINDOW_MIN_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic                     heartbeat,
  input  logic                     force_reset,
  output logic                     warning,
  output logic                     triggered,
  output logic                     trigger_pulse,
  output logic [COUNTER_WIDTH-1:0] count
);

  localparam logic [COUNTER_WIDTH-1:0] LAST =
    COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] WARN_PREV =
    COUNTER_WIDTH'(WARNING_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] WIN_MIN =
    COUNTER_WIDTH'(WINDOW_MIN_CYCLES);

`ifdef WDT_WINDOW_EN
  localparam bit WINDOW_ON = 1'b1;
`else
  localparam bit WINDOW_ON = 1'b0;
`endif

  logic early_kick;
  logic at_last;

  assign early_kick = WINDOW_ON && (count < WIN_MIN);
  assign at_last    = (count == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count         <= '0;
      warning       <= 1'b0;
      triggered     <= 1'b0;
      trigger_pulse <= 1'b0;
    end else begin
      trigger_pulse <= 1'b0;
      if (force_reset) begin
        triggered     <= 1'b1;
        warning       <= 1'b0;
        trigger_pulse <= !triggered;
      end else if (!enable) begin
        count     <= '0;
        warning   <= 1'b0;
        triggered <= 1'b0;
      end else if (triggered) begin
        count <= count;
      end else if (heartbeat && early_kick) begin
        triggered     <= 1'b1;
        trigger_pulse <= 1'b1;
        warning       <= 1'b0;
      end else if (heartbeat) begin
        count   <= '0;
        warning <= 1'b0;
      end else if (at_last) begin
        triggered     <= 1'b1;
        trigger_pulse <= 1'b1;
        warning       <= 1'b0;
      end else begin
        // count < LAST here, so count+1 >= WARNING is count >= WARNING-1
        count <= count + 1'b1;
        if (count >= WARN_PREV)
          warning <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_watchdog_timer_unit.sv
// Directed bench for watchdog_timer_unit with default parameters.
// Window-mode steps run only when WDT_WINDOW_EN is defined.
module tb_watchdog_timer_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        heartbeat;
  logic        force_reset;
  logic        warning;
  logic        triggered;
  logic        trigger_pulse;
  logic [31:0] count;

  int errors = 0;
  int checks = 0;
  int max_cnt;
  int saw_warn;
  int saw_trig;

  watchdog_timer_unit dut (
    .clk(clk),
    .rstn(rstn),
    .enable(enable),
    .heartbeat(heartbeat),
    .force_reset(force_reset),
    .warning(warning),
    .triggered(triggered),
    .trigger_pulse(trigger_pulse),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] c,
                           input logic w, input logic t, input logic p);
    check({tag, ".count"}, count, c);
    check({tag, ".warning"}, {31'd0, warning}, {31'd0, w});
    check({tag, ".triggered"}, {31'd0, triggered}, {31'd0, t});
    check({tag, ".pulse"}, {31'd0, trigger_pulse}, {31'd0, p});
  endtask

  initial begin
    rstn = 1'b0;
    enable = 1'b0;
    heartbeat = 1'b0;
    force_reset = 1'b0;
    #12;
    check_all("reset", 0, 0, 0, 0);

    // free-run to timeout
    tick(1);
    rstn = 1'b1;
    enable = 1'b1;
    tick(15);
    check_all("edge15", 15, 1, 0, 0);
    tick(4);
    check_all("edge19", 19, 1, 0, 0);
    tick(1);
    check_all("edge20", 19, 0, 1, 1);
    tick(1);
    check_all("edge21", 19, 0, 1, 0);

    // kick while tripped is ignored
    heartbeat = 1'b1;
    tick(1);
    heartbeat = 1'b0;
    check_all("kick_trip", 19, 0, 1, 0);

    // disable clears, re-enable restarts
    enable = 1'b0;
    tick(2);
    check_all("disable", 0, 0, 0, 0);
    enable = 1'b1;
    tick(3);
    check_all("reenable", 3, 0, 0, 0);

    // periodic heartbeat every 10th cycle
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    max_cnt = 0;
    saw_warn = 0;
    saw_trig = 0;
    for (int i = 0; i < 100; i++) begin
      heartbeat = (i % 10 == 9);
      tick(1);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (warning) saw_warn++;
      if (triggered) saw_trig++;
    end
    heartbeat = 1'b0;
    check("periodic.max_le10", {31'd0, max_cnt <= 10}, 32'd1);
    check("periodic.max", max_cnt, 9);
    check("periodic.warn", saw_warn, 0);
    check("periodic.trig", saw_trig, 0);
    check("periodic.end", count, 0);

    // warning cleared by kick
    tick(17);
    check_all("run17", 17, 1, 0, 0);
    heartbeat = 1'b1;
    tick(1);
    heartbeat = 1'b0;
    check_all("kick17", 0, 0, 0, 0);
    tick(19);
    check_all("newper19", 19, 1, 0, 0);

    // kick on the would-be timeout edge wins
    heartbeat = 1'b1;
    tick(1);
    heartbeat = 1'b0;
    check_all("kick_last", 0, 0, 0, 0);

    // force reset
    tick(5);
    check("pre_force", count, 5);
    force_reset = 1'b1;
    tick(1);
    force_reset = 1'b0;
    check_all("force1", 5, 0, 1, 1);
    tick(1);
    check_all("force1b", 5, 0, 1, 0);
    force_reset = 1'b1;
    tick(1);
    force_reset = 1'b0;
    check_all("force2", 5, 0, 1, 0);

    // force while disabled still trips
    enable = 1'b0;
    tick(1);
    force_reset = 1'b1;
    tick(1);
    force_reset = 1'b0;
    check_all("force_dis", 0, 0, 1, 1);

    // async reset mid-count with warning high
    enable = 1'b1;
    tick(1);
    check_all("en_after_force", 0, 0, 1, 0);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(16);
    check_all("pre_async", 16, 1, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0);

`ifdef WDT_WINDOW_EN
    tick(1);
    rstn = 1'b1;
    tick(2);
    check("win_pre", count, 2);
    heartbeat = 1'b1;
    tick(1);
    heartbeat = 1'b0;
    check_all("win_early", 2, 0, 1, 1);
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    tick(6);
    check("win_pre6", count, 6);
    heartbeat = 1'b1;
    tick(1);
    heartbeat = 1'b0;
    check_all("win_ok", 0, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
